// File: rtl/obuf_pkg.sv
// Shared types and constants for the output-buffer accumulation controller.
package obuf_pkg;

    localparam int unsigned LANES = 4;
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_LOAD,
        S_ACC,
        S_WSUM,
        S_WR,
        S_DONE
    } state_t;

endpackage

// File: rtl/obuf_addr_gen.sv
// Tile address generator: latches base/length on load, steps once per written word.
module obuf_addr_gen #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              step,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last_c
);

    logic [ADDR_W-1:0] words_left;

    // address wraps naturally modulo 2^ADDR_W
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_addr   <= '0;
            words_left <= '0;
        end else if (load) begin
            cur_addr   <= base_addr;
            words_left <= num_words;
        end else if (step) begin
            cur_addr   <= cur_addr + ADDR_W'(1);
            words_left <= words_left - ADDR_W'(1);
        end
    end

    assign last_c = (words_left == ADDR_W'(1));

endmodule

// File: rtl/obuf_acc_ctrl.sv
// Output-buffer accumulation sequencer: read partial sum, feed 4 segments, write sum back.
// Optional OBUF_CTRL_PERF_EN adds a saturating stall counter output STALL_CNT.
module obuf_acc_ctrl
    import obuf_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned SEG_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [ADDR_W-1:0]       BASE_ADDR,
    input  logic [ADDR_W-1:0]       NUM_WORDS,
    input  logic                    ACCUM,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic                    SEG_EN,
    output logic                    PREV_LD,
    output logic [LANES*SEG_W-1:0]  PREV_O,
    input  logic                    SUM_VALID,
    input  logic [LANES*SEG_W-1:0]  SUM_I,
    output logic                    EN_O,
    output logic                    RW_O,
    output logic [ADDR_W-1:0]       ADDR_O,
    input  logic [LANES*SEG_W-1:0]  RDATA_I,
    output logic [LANES*SEG_W-1:0]  WDATA_O,
`ifdef OBUF_CTRL_PERF_EN
    output logic [15:0]             STALL_CNT,
`endif
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int unsigned LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned SEG_CNT_W = $clog2(LANES);

    state_t               state, state_nxt;
    logic                 accum_q;
    logic [LAT_W-1:0]     lat_cnt;
    logic [SEG_CNT_W-1:0] seg_cnt;
    logic                 lat_last_c;
    logic                 last_c;
    logic                 start_c;

    assign start_c    = (state == S_IDLE) && START;
    assign lat_last_c = (lat_cnt == LAT_W'(RD_LAT - 1));
    assign SEG_EN     = IN_VALID & IN_READY;

    obuf_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .CLK       (CLK),
        .RST       (RST),
        .load      (start_c),
        .base_addr (BASE_ADDR),
        .num_words (NUM_WORDS),
        .step      (state == S_WR),
        .cur_addr  (ADDR_O),
        .last_c    (last_c)
    );

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    if (NUM_WORDS == '0) state_nxt = S_DONE;
                    else if (ACCUM)      state_nxt = S_RD_REQ;
                    else                 state_nxt = S_LOAD;
                end
            end
            S_RD_REQ:  state_nxt = S_RD_WAIT;
            S_RD_WAIT: if (lat_last_c) state_nxt = S_LOAD;
            S_LOAD:    state_nxt = S_ACC;
            S_ACC:     if (SEG_EN && (seg_cnt == SEG_CNT_W'(LANES - 1))) state_nxt = S_WSUM;
            S_WSUM:    if (SUM_VALID) state_nxt = S_WR;
            S_WR: begin
                if (last_c)       state_nxt = S_DONE;
                else if (accum_q) state_nxt = S_RD_REQ;
                else              state_nxt = S_LOAD;
            end
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // state register; state-decoded outputs registered from next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            EN_O     <= 1'b0;
            RW_O     <= RW_READ;
            IN_READY <= 1'b0;
            PREV_LD  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            state    <= state_nxt;
            EN_O     <= (state_nxt == S_RD_REQ) || (state_nxt == S_WR);
            RW_O     <= (state_nxt == S_WR) ? RW_WRITE : RW_READ;
            IN_READY <= (state_nxt == S_ACC);
            PREV_LD  <= (state_nxt == S_LOAD);
            BUSY     <= (state_nxt != S_IDLE);
            DONE     <= (state_nxt == S_DONE);
        end
    end

    // datapath registers and counters
    always_ff @(posedge CLK) begin
        if (RST) begin
            accum_q <= 1'b0;
            lat_cnt <= '0;
            seg_cnt <= '0;
            PREV_O  <= '0;
            WDATA_O <= '0;
        end else begin
            if (start_c) accum_q <= ACCUM;

            if (state == S_RD_WAIT) lat_cnt <= lat_last_c ? '0 : lat_cnt + LAT_W'(1);
            else                    lat_cnt <= '0;

            if (state == S_LOAD)                seg_cnt <= '0;
            else if ((state == S_ACC) && SEG_EN) seg_cnt <= seg_cnt + SEG_CNT_W'(1);

            // first-pass words start from zero instead of a stored sum
            if ((state == S_RD_WAIT) && lat_last_c)                 PREV_O <= RDATA_I;
            else if ((state_nxt == S_LOAD) && (state != S_RD_WAIT)) PREV_O <= '0;

            if ((state == S_WSUM) && SUM_VALID) WDATA_O <= SUM_I;
        end
    end

`ifdef OBUF_CTRL_PERF_EN
    always_ff @(posedge CLK) begin
        if (RST)                                                   STALL_CNT <= '0;
        else if (start_c)                                          STALL_CNT <= '0;
        else if ((state == S_ACC) && !IN_VALID && (STALL_CNT != 16'hFFFF)) STALL_CNT <= STALL_CNT + 16'd1;
    end
`endif

endmodule
